// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sharing one combinational alu between two requesters
module alu_share_arb #(
    parameter int              DATA_W = 32,
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] NOP_OP = '0
) (
    input  logic              clk,
    input  logic              rstn,
    // requester 0
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [DATA_W-1:0] r0_pc,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_c,
    output logic              r0_zero,
    // requester 1
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [DATA_W-1:0] r1_pc,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_c,
    output logic              r1_zero,
    // shared alu
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_pc,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                owner_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   pc_q;
    logic [DATA_W-1:0]   c_q;
    logic                zero_q;

    logic                grant_valid;
    logic                grant_sel;
    logic                resp_fire;

    // Round-robin grant, only offered while idle and out of reset; a tie goes to
    // the port that did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (rstn && (state_q == IDLE)) begin
            if (r0_valid && r1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant_q;
            end else if (r0_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (r1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    assign r0_ready  = grant_valid & ~grant_sel;
    assign r1_ready  = grant_valid &  grant_sel;

    // Response belongs to the owner only; the result registers are shared.
    assign r0_rvalid = rstn & (state_q == RESP) & ~owner_q;
    assign r1_rvalid = rstn & (state_q == RESP) &  owner_q;
    assign r0_c      = c_q;
    assign r1_c      = c_q;
    assign r0_zero   = zero_q;
    assign r1_zero   = zero_q;

    assign resp_fire = (state_q == RESP) & (owner_q ? r1_rready : r0_rready);

    // The alu only sees the latched operands while evaluating; otherwise a NOP.
    always_comb begin
        alu_op = NOP_OP;
        alu_a  = '0;
        alu_b  = '0;
        alu_pc = '0;
        if (state_q == EXEC) begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
            alu_pc = pc_q;
        end
    end

    // Arbitration FSM: latch the winner, capture the alu result, hold it until consumed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= NOP_OP;
            a_q          <= '0;
            b_q          <= '0;
            pc_q         <= '0;
            c_q          <= '0;
            zero_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q <= grant_sel;
                        op_q    <= grant_sel ? r1_op : r0_op;
                        a_q     <= grant_sel ? r1_a  : r0_a;
                        b_q     <= grant_sel ? r1_b  : r0_b;
                        pc_q    <= grant_sel ? r1_pc : r0_pc;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    c_q     <= alu_c;
                    zero_q  <= alu_zero;
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_fire) begin
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb
module tb_alu_share_arb;

    localparam int DW = 32;
    localparam int OW = 5;

    localparam logic [OW-1:0] OP_AUIPC = 5'b00010;
    localparam logic [OW-1:0] OP_ADD   = 5'b00011;
    localparam logic [OW-1:0] OP_SUB   = 5'b00100;
    localparam logic [OW-1:0] OP_XOR   = 5'b00101;

    logic          clk = 1'b0;
    logic          rstn;
    logic          r0_valid, r0_ready, r0_rvalid, r0_rready, r0_zero;
    logic [OW-1:0] r0_op;
    logic [DW-1:0] r0_a, r0_b, r0_pc, r0_c;
    logic          r1_valid, r1_ready, r1_rvalid, r1_rready, r1_zero;
    logic [OW-1:0] r1_op;
    logic [DW-1:0] r1_a, r1_b, r1_pc, r1_c;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_pc, alu_c;
    logic          alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference alu the arbiter is attached to.
    always_comb begin
        alu_c = '0;
        case (alu_op)
            OP_AUIPC: alu_c = alu_pc + alu_b;
            OP_ADD:   alu_c = alu_a + alu_b;
            OP_SUB:   alu_c = alu_a - alu_b;
            OP_XOR:   alu_c = alu_a ^ alu_b;
            default:  alu_c = '0;
        endcase
        alu_zero = (alu_c == '0);
    end

    alu_share_arb #(.DATA_W(DW), .OP_W(OW), .NOP_OP(5'b00000)) dut (
        .clk(clk), .rstn(rstn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a),
        .r0_b(r0_b), .r0_pc(r0_pc), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
        .r0_c(r0_c), .r0_zero(r0_zero),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a),
        .r1_b(r1_b), .r1_pc(r1_pc), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
        .r1_c(r1_c), .r1_zero(r1_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc),
        .alu_c(alu_c), .alu_zero(alu_zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        r0_valid = 1'b1; r1_valid = 1'b1;
        rstn = 1'b0;
        tick(); tick();
        checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL rst_r0_ready: got %b want 0", r0_ready); end
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL rst_r1_ready: got %b want 0", r1_ready); end
        checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", r0_rvalid, r1_rvalid); end
        checks++; if (r0_c !== 32'h0 || r0_zero !== 1'b0) begin errors++; $display("FAIL rst_result: got c=%h z=%b want c=0 z=0", r0_c, r0_zero); end
        checks++; if (alu_op !== 5'b00000 || alu_a !== 32'h0) begin errors++; $display("FAIL rst_alu: got op=%b a=%h want op=00000 a=0", alu_op, alu_a); end
        r0_valid = 1'b0; r1_valid = 1'b0;
        rstn = 1'b1;
        settle();
    endtask

    task automatic test_single_add();
        r0_op = OP_ADD; r0_a = 32'd5; r0_b = 32'd7; r0_valid = 1'b1;
        settle();
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL add_ready: got %b%b want r0=1 r1=0", r0_ready, r1_ready); end
        tick();
        r0_valid = 1'b0;
        settle();
        checks++; if (alu_op !== OP_ADD || alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("FAIL add_exec_drive: got op=%b a=%0d b=%0d want 00011 5 7", alu_op, alu_a, alu_b); end
        checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL add_early_rvalid: got %b want 0", r0_rvalid); end
        tick();
        checks++; if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL add_rvalid: got r0=%b r1=%b want 1 0", r0_rvalid, r1_rvalid); end
        checks++; if (r0_c !== 32'd12 || r0_zero !== 1'b0) begin errors++; $display("FAIL add_result: got c=%0d z=%b want 12 0", r0_c, r0_zero); end
        checks++; if (alu_op !== 5'b00000) begin errors++; $display("FAIL add_resp_nop: got %b want 00000", alu_op); end
        r0_rready = 1'b1;
        tick();
        r0_rready = 1'b0;
        settle();
        checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL add_rvalid_clear: got %b want 0", r0_rvalid); end
    endtask

    task automatic test_tie();
        apply_reset();
        r0_op = OP_SUB; r0_a = 32'd9; r0_b = 32'd9; r0_valid = 1'b1;
        r1_op = OP_XOR; r1_a = 32'hF0; r1_b = 32'h0F; r1_valid = 1'b1;
        settle();
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL tie_first: got r0=%b r1=%b want 1 0", r0_ready, r1_ready); end
        tick();
        r0_valid = 1'b0;
        settle();
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL tie_exec_wait: got %b want 0", r1_ready); end
        tick();
        checks++; if (r0_rvalid !== 1'b1 || r0_c !== 32'h0 || r0_zero !== 1'b1) begin errors++; $display("FAIL tie_r0_result: got v=%b c=%h z=%b want 1 0 1", r0_rvalid, r0_c, r0_zero); end
        r0_rready = 1'b1;
        settle();
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL tie_handshake_noaccept: got %b want 0", r1_ready); end
        tick();
        r0_rready = 1'b0;
        settle();
        checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin errors++; $display("FAIL tie_second: got r0=%b r1=%b want 0 1", r0_ready, r1_ready); end
        tick();
        r1_valid = 1'b0;
        tick();
        checks++; if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0) begin errors++; $display("FAIL tie_r1_rvalid: got r0=%b r1=%b want 0 1", r0_rvalid, r1_rvalid); end
        checks++; if (r1_c !== 32'hFF || r1_zero !== 1'b0) begin errors++; $display("FAIL tie_r1_result: got c=%h z=%b want ff 0", r1_c, r1_zero); end
        r1_rready = 1'b1;
        tick();
        r1_rready = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        settle();
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL tie_next_rr: got r0=%b r1=%b want 1 0", r0_ready, r1_ready); end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        checks++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || alu_op !== 5'b00000) begin errors++; $display("FAIL tie_drop_valid: got rdy=%b%b op=%b want 00 00000", r0_ready, r1_ready, alu_op); end
    endtask

    task automatic test_backpressure();
        r0_op = OP_ADD; r0_a = 32'd1; r0_b = 32'd2; r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        tick();
        r1_op = OP_ADD; r1_a = 32'd40; r1_b = 32'd2; r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (r0_rvalid !== 1'b1 || r0_c !== 32'd3) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b c=%0d want 1 3", i, r0_rvalid, r0_c); end
            checks++; if (r1_ready !== 1'b0 || alu_op !== 5'b00000) begin errors++; $display("FAIL bp_block[%0d]: got r1_ready=%b op=%b want 0 00000", i, r1_ready, alu_op); end
        end
        r0_rready = 1'b1;
        tick();
        r0_rready = 1'b0;
        settle();
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", r1_ready); end
        r1_valid = 1'b0;
        settle();
    endtask

    task automatic test_reset_exec();
        r0_op = OP_ADD; r0_a = 32'd3; r0_b = 32'd4; r0_valid = 1'b1;
        tick();
        r0_valid = 1'b0;
        rstn = 1'b0;
        tick();
        checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL rx_rvalid_in_rst: got %b%b want 00", r0_rvalid, r1_rvalid); end
        checks++; if (r0_c !== 32'h0) begin errors++; $display("FAIL rx_c_cleared: got %0d want 0", r0_c); end
        rstn = 1'b1;
        tick();
        checks++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errors++; $display("FAIL rx_rvalid_after: got %b%b want 00", r0_rvalid, r1_rvalid); end
        r0_valid = 1'b1; r1_valid = 1'b1;
        settle();
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin errors++; $display("FAIL rx_tie_r0: got r0=%b r1=%b want 1 0", r0_ready, r1_ready); end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
    endtask

    task automatic test_auipc();
        r1_op = OP_AUIPC; r1_a = 32'h55; r1_b = 32'h20; r1_pc = 32'h100; r1_valid = 1'b1;
        settle();
        checks++; if (alu_pc !== 32'h0 || alu_op !== 5'b00000) begin errors++; $display("FAIL auipc_idle_drive: got pc=%h op=%b want 0 00000", alu_pc, alu_op); end
        tick();
        r1_valid = 1'b0;
        settle();
        checks++; if (alu_op !== OP_AUIPC || alu_pc !== 32'h100 || alu_b !== 32'h20) begin errors++; $display("FAIL auipc_exec_drive: got op=%b pc=%h b=%h want 00010 100 20", alu_op, alu_pc, alu_b); end
        tick();
        checks++; if (r1_rvalid !== 1'b1 || r1_c !== 32'h120) begin errors++; $display("FAIL auipc_result: got v=%b c=%h want 1 120", r1_rvalid, r1_c); end
        checks++; if (alu_pc !== 32'h0) begin errors++; $display("FAIL auipc_resp_drive: got %h want 0", alu_pc); end
        r1_rready = 1'b1;
        tick();
        r1_rready = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        int nacc = 0;
        int nres = 0;
        int k = 1;
        int acc_cyc [8];
        logic [DW-1:0] res [8];
        logic got_acc;
        r1_op = OP_ADD; r1_a = 32'd1; r1_b = 32'd100; r1_valid = 1'b1; r1_rready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            settle();
            got_acc = r1_ready;
            if (r1_ready && nacc < 8) begin acc_cyc[nacc] = cyc; nacc++; end
            if (r1_rvalid && nres < 8) begin res[nres] = r1_c; nres++; end
            tick();
            if (got_acc) begin k++; r1_a = k; end
        end
        r1_valid = 1'b0; r1_rready = 1'b0;
        checks++; if (nacc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", nacc); end
        checks++; if (nres !== 4) begin errors++; $display("FAIL b2b_results: got %0d want 4", nres); end
        for (int i = 0; i < 4; i++) begin
            if (i < nacc) begin
                checks++; if (acc_cyc[i] !== 3 * i) begin errors++; $display("FAIL b2b_spacing[%0d]: got cycle %0d want %0d", i, acc_cyc[i], 3 * i); end
            end
            if (i < nres) begin
                checks++; if (res[i] !== 32'(101 + i)) begin errors++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, res[i], 101 + i); end
            end
        end
        settle();
    endtask

    initial begin
        rstn = 1'b0;
        r0_valid = 1'b0; r0_rready = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0; r0_pc = '0;
        r1_valid = 1'b0; r1_rready = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0; r1_pc = '0;
        test_reset();
        test_single_add();
        test_tie();
        test_backpressure();
        test_reset_exec();
        test_auipc();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
